decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Scan sequencer directly upstream of the 3-to-8 decoder; drives the decoder's 3-bit select and enable so one output line at a time is active (display digit / row strobing).
- Steps through channels 0..7 with a programmable dwell and an optional blanking gap between channels (anti-ghosting).
- Runs continuously after start, finishes the current frame on stop, and reports frame completion and a frame count.

Parameters:
- DWELL, 4, cycles en is held high per channel; legal range >= 1.
- BLANK, 1, cycles en is held low between consecutive channels; legal range >= 0 (0 = no gap).
- CNT_W, 8, width of frame_cnt.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level sampled each clk; begins scanning from IDLE.
- stop  input  1  request to end scanning at the next frame boundary.
- mask  input  8  channel enable mask; used only with SCAN_SKIP_EN.
- sel  output  3  channel select to decoder A.
- en  output  1  decoder enable E.
- busy  output  1  high while not in IDLE.
- frame_done  output  1  one-cycle pulse at end of each frame.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sel=0, en=0, busy=0, frame_done=0, frame_cnt=0, stop-pending flag cleared; applies mid-scan, overriding all other inputs.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, DRIVE, GAP.
- IDLE: en=0, sel=0, busy=0. start=1 sampled -> next cycle DRIVE, sel=first channel, en=1, busy=1. stop ignored in IDLE, except start and stop sampled together -> run exactly one frame, then IDLE.
- DRIVE: en=1 for exactly DWELL cycles with sel constant. After the last DRIVE cycle:
  - if BLANK>0 -> GAP (en=0, sel unchanged) for BLANK cycles, then DRIVE on the next channel;
  - if BLANK=0 -> DRIVE on the next channel immediately (en stays high, sel changes).
- Channel order: 0,1,...,7, wrap to 0. Full frame period = 8*(DWELL+BLANK) cycles.
- Frame boundary = cycle after the last DRIVE cycle of channel 7 (last enabled channel with SCAN_SKIP_EN). In that cycle:
  - frame_done=1 for one cycle;
  - frame_cnt increments (2^CNT_W-1 wraps to 0).
- stop=1 in DRIVE/GAP sets the stop-pending flag, held until consumed. At the frame boundary, if the flag is set:
  - state goes to IDLE, en=0, sel=0, busy=0 in the same cycle as the frame_done pulse;
  - no trailing gap; flag cleared.
- start while busy: ignored.
- The decoder never sees en=1 with sel changing inside a channel; sel changes only at a channel transition.

Optional Feature:
- Macro: SCAN_SKIP_EN.
- Defined:
  - Channels with mask[i]=0 are skipped: no DRIVE and no GAP for them.
  - mask is sampled when the next channel is selected.
  - The frame boundary follows the highest-numbered enabled channel.
  - start with mask=0 is ignored.
  - If mask becomes 0 mid-scan, the current channel completes, then frame_done pulses and the block returns to IDLE.
- Not defined: mask is ignored; all 8 channels are scanned; behaviour is exactly as above.

Test Plan:
- Reset, then start pulse at cycle 0 -> cycle 1: sel=0, en=1, busy=1; en high cycles 1-4, low cycle 5 (gap), sel=1 with en high cycles 6-9.
- Free-run 2 frames with defaults -> frame_done pulses at cycles 40 and 80, frame_cnt=1 then 2, en high for exactly 32 cycles per frame.
- stop asserted at cycle 12 (mid-frame) -> scan continues to channel 7, frame_done at cycle 40 with busy=0, en=0, sel=0 same cycle; later start restarts from sel=0.
- BLANK=0, DWELL=1 -> sel increments every cycle 0..7 with en constantly 1, frame_done every 8 cycles; CNT_W=3 run 8 frames -> frame_cnt wraps 7 to 0.
- rst asserted at cycle 20 (mid-scan, pending stop) -> next cycle all outputs at reset values; no frame_done pulse.
- SCAN_SKIP_EN defined, mask=8'b1000_0101 -> sequence sel 0,2,7 repeating, frame period 15 cycles; mask=0 at start -> stays IDLE.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scan sequencer feeding a 3-to-8 decoder.
// Drives sel/en so one decoder line at a time is active: DWELL cycles of
// drive per channel, BLANK cycles of blanking between channels, channels
// 0..7 in order. Reports frame completion and a wrapping frame count.
// Optional feature macro: SCAN_SKIP_EN (skip channels whose mask bit is 0).
module decoder_scan_ctrl #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       mask,
    output logic [2:0]       sel,
    output logic             en,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    // Phase counter must hold DWELL-1 and BLANK-1.
    localparam int unsigned PH_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] DWELL_LD = PH_W'(DWELL - 1);
    localparam logic [PH_W-1:0] BLANK_LD = (BLANK > 0) ? PH_W'(BLANK - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               pend_q, pend_d;
    logic [2:0]         nxt_q, nxt_d;

    logic [7:0]         scan_mask;
    logic [3:0]         first_hit;
    logic [3:0]         next_hit;
    logic [2:0]         ch_next;
    logic               wrap;
    logic               halt;

`ifdef SCAN_SKIP_EN
    assign scan_mask = mask;
`else
    logic unused_mask;
    assign scan_mask   = '1;
    assign unused_mask = ^mask;
`endif

    // Lowest enabled channel at or above 'from'; bit 3 flags a hit.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!r[3] && m[i] && (i >= 32'(from))) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    assign first_hit = find_from(scan_mask, 4'd0);
    assign next_hit  = find_from(scan_mask, {1'b0, sel_q} + 4'd1);
    // No enabled channel above the current one: this channel ends the frame.
    assign wrap      = !next_hit[3];
    assign ch_next   = next_hit[3] ? next_hit[2:0] : first_hit[2:0];
    // Leave at the frame boundary on a pending/concurrent stop or an empty mask.
    assign halt      = wrap && (pend_q || stop || !first_hit[3]);

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ph_q    <= '0;
            pend_q  <= 1'b0;
            nxt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pend_q  <= pend_d;
            nxt_q   <= nxt_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pend_d  = pend_q;
        nxt_d   = nxt_q;

        unique case (state_q)
            IDLE: begin
                if (start && first_hit[3]) begin
                    state_d = DRIVE;
                    sel_d   = first_hit[2:0];
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    ph_d    = DWELL_LD;
                    pend_d  = stop;
                end
            end

            DRIVE: begin
                if (stop) begin
                    pend_d = 1'b1;
                end
                if (ph_q != '0) begin
                    ph_d = ph_q - PH_W'(1);
                end else begin
                    if (wrap) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    if (halt) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        pend_d  = 1'b0;
                    end else if (BLANK > 0) begin
                        state_d = GAP;
                        en_d    = 1'b0;
                        ph_d    = BLANK_LD;
                        nxt_d   = ch_next;
                    end else begin
                        sel_d = ch_next;
                        ph_d  = DWELL_LD;
                    end
                end
            end

            GAP: begin
                if (stop) begin
                    pend_d = 1'b1;
                end
                if (ph_q != '0) begin
                    ph_d = ph_q - PH_W'(1);
                end else begin
                    state_d = DRIVE;
                    sel_d   = nxt_q;
                    en_d    = 1'b1;
                    ph_d    = DWELL_LD;
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: two instances (defaults, and DWELL=1/BLANK=0/
// CNT_W=3) share stimulus; a frame-position model predicts every output.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] mask;

    logic [2:0] sel0, sel1;
    logic       en0, en1, busy0, busy1, fd0, fd1;
    logic [7:0] cnt0;
    logic [2:0] cnt1;

    int unsigned n_err;
    int unsigned n_chk;

    decoder_scan_ctrl #(.DWELL(4), .BLANK(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
        .sel(sel0), .en(en0), .busy(busy0), .frame_done(fd0), .frame_cnt(cnt0)
    );

    decoder_scan_ctrl #(.DWELL(1), .BLANK(0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
        .sel(sel1), .en(en1), .busy(busy1), .frame_done(fd1), .frame_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model configuration per instance.
    int unsigned md[2] = '{4, 1};
    int unsigned mb[2] = '{1, 0};
    int unsigned mw[2] = '{8, 3};

    // Model state: running flag, cycles since first drive, stop pending,
    // frame count, and the ordered list of channels in a frame.
    bit          m_run[2];
    int unsigned m_k[2];
    bit          m_pend[2];
    int unsigned m_cnt[2];
    int unsigned m_n[2];
    int unsigned m_ch[2][8];
    int unsigned e_sel[2], e_en[2], e_busy[2], e_fd[2], e_cnt[2];
    bit          armed;

    logic s_rst, s_start, s_stop;
`ifdef SCAN_SKIP_EN
    logic [7:0] s_mask;
`endif

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0]  ms;
        int unsigned s, per, e, p;
`ifdef SCAN_SKIP_EN
        ms = s_mask;
`else
        ms = 8'hFF;
`endif
        if (s_rst) armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_fd[i] = 0;
            if (s_rst) begin
                m_run[i]  = 1'b0;
                m_k[i]    = 0;
                m_pend[i] = 1'b0;
                m_cnt[i]  = 0;
            end else if (!m_run[i]) begin
                m_n[i] = 0;
                for (int c = 0; c < 8; c++) begin
                    if (ms[c]) begin
                        m_ch[i][m_n[i]] = c;
                        m_n[i]++;
                    end
                end
                if (s_start && m_n[i] > 0) begin
                    m_run[i]  = 1'b1;
                    m_k[i]    = 0;
                    m_pend[i] = s_stop;
                end
            end else begin
                s   = md[i] + mb[i];
                per = m_n[i] * s;
                e   = (m_n[i] - 1) * s + md[i];
                if (s_stop) m_pend[i] = 1'b1;
                m_k[i]++;
                if (m_k[i] >= e && (m_k[i] - e) % per == 0) begin
                    e_fd[i]  = 1;
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << mw[i]);
                    if (m_pend[i]) begin
                        m_run[i]  = 1'b0;
                        m_pend[i] = 1'b0;
                    end
                end
            end
            e_busy[i] = m_run[i] ? 1 : 0;
            e_cnt[i]  = m_cnt[i];
            if (m_run[i]) begin
                s        = md[i] + mb[i];
                per      = m_n[i] * s;
                p        = m_k[i] % per;
                e_sel[i] = m_ch[i][p / s];
                e_en[i]  = ((p % s) < md[i]) ? 1 : 0;
            end else begin
                e_sel[i] = 0;
                e_en[i]  = 0;
            end
        end
    endtask

    // Compare process: inputs captured at the active edge, outputs checked
    // on the falling edge against the model.
    initial begin
        armed = 1'b0;
        forever begin
            @(posedge clk);
            s_rst   = rst;
            s_start = start;
            s_stop  = stop;
`ifdef SCAN_SKIP_EN
            s_mask  = mask;
`endif
            @(negedge clk);
            model_step();
            if (armed) begin
                chk("sel0",  sel0,  e_sel[0]);
                chk("en0",   en0,   e_en[0]);
                chk("busy0", busy0, e_busy[0]);
                chk("fd0",   fd0,   e_fd[0]);
                chk("cnt0",  cnt0,  e_cnt[0]);
                chk("sel1",  sel1,  e_sel[1]);
                chk("en1",   en1,   e_en[1]);
                chk("busy1", busy1, e_busy[1]);
                chk("fd1",   fd1,   e_fd[1]);
                chk("cnt1",  cnt1,  e_cnt[1]);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int unsigned en_hi_a, en_hi_b;

    initial begin
        n_err = 0;
        n_chk = 0;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mask  = 8'hFF;
        tick(2);
        chk("rst_sel0",  sel0,  0);
        chk("rst_en0",   en0,   0);
        chk("rst_busy0", busy0, 0);
        chk("rst_fd0",   fd0,   0);
        chk("rst_cnt0",  cnt0,  0);
        rst = 1'b0;

        // Free run two frames from a start pulse at cycle 0.
        start   = 1'b1;
        en_hi_a = 0;
        en_hi_b = 0;
        for (int unsigned c = 1; c <= 80; c++) begin
            tick(1);
            if (c == 1) start = 1'b0;
            if (c <= 40) en_hi_a += en0; else en_hi_b += en0;
            case (c)
                1: begin
                    chk("c1_sel0", sel0, 0); chk("c1_en0", en0, 1); chk("c1_busy0", busy0, 1);
                    chk("c1_sel1", sel1, 0); chk("c1_en1", en1, 1);
                    chk("model_c1_en", e_en[0], 1);
                end
                2: chk("c2_sel1", sel1, 1);
                4: begin chk("c4_en0", en0, 1); chk("c4_sel0", sel0, 0); end
                5: begin chk("c5_en0", en0, 0); chk("c5_sel0", sel0, 0); chk("model_c5_en", e_en[0], 0); end
                6: begin chk("c6_sel0", sel0, 1); chk("c6_en0", en0, 1); chk("model_c6_sel", e_sel[0], 1); end
                8: begin chk("c8_sel1", sel1, 7); chk("c8_en1", en1, 1); end
                9: begin chk("c9_fd1", fd1, 1); chk("c9_cnt1", cnt1, 1); chk("c9_sel1", sel1, 0); chk("c9_en1", en1, 1); end
                39: begin chk("c39_sel0", sel0, 7); chk("c39_fd0", fd0, 0); end
                40: begin
                    chk("c40_fd0", fd0, 1); chk("c40_cnt0", cnt0, 1); chk("c40_en0", en0, 0);
                    chk("model_c40_fd", e_fd[0], 1); chk("model_c40_cnt", e_cnt[0], 1);
                end
                41: begin chk("c41_fd0", fd0, 0); chk("c41_sel0", sel0, 0); chk("c41_en0", en0, 1); end
                57: chk("c57_cnt1", cnt1, 7);
                65: begin chk("c65_cnt1_wrap", cnt1, 0); chk("c65_fd1", fd1, 1); end
                80: begin chk("c80_fd0", fd0, 1); chk("c80_cnt0", cnt0, 2); end
                default: ;
            endcase
        end
        chk("frame1_en_cycles", en_hi_a, 32);
        chk("frame2_en_cycles", en_hi_b, 32);

        // Stop mid-frame: finish frame, drop to IDLE with the frame_done pulse.
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b1;
        for (int unsigned c = 1; c <= 46; c++) begin
            tick(1);
            if (c == 1) start = 1'b0;
            if (c == 12) stop = 1'b1;
            if (c == 13) stop = 1'b0;
            case (c)
                39: begin chk("s39_busy0", busy0, 1); chk("s39_sel0", sel0, 7); chk("s39_en0", en0, 1); end
                40: begin
                    chk("s40_fd0", fd0, 1); chk("s40_busy0", busy0, 0);
                    chk("s40_en0", en0, 0); chk("s40_sel0", sel0, 0); chk("s40_cnt0", cnt0, 1);
                end
                41: begin chk("s41_fd0", fd0, 0); chk("s41_busy0", busy0, 0); end
                45: start = 1'b1;
                46: begin start = 1'b0; chk("s46_sel0", sel0, 0); chk("s46_en0", en0, 1); chk("s46_busy0", busy0, 1); end
                default: ;
            endcase
        end

        // Reset mid-scan with a stop pending.
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b1;
        for (int unsigned c = 1; c <= 71; c++) begin
            tick(1);
            if (c == 1) start = 1'b0;
            if (c == 15) stop = 1'b1;
            if (c == 16) stop = 1'b0;
            case (c)
                20: rst = 1'b1;
                21: begin
                    rst = 1'b0;
                    chk("r21_sel0", sel0, 0); chk("r21_en0", en0, 0); chk("r21_busy0", busy0, 0);
                    chk("r21_fd0", fd0, 0); chk("r21_cnt0", cnt0, 0); chk("r21_busy1", busy1, 0);
                end
                30: begin chk("r30_busy0", busy0, 0); start = 1'b1; end
                31: begin start = 1'b0; chk("r31_busy0", busy0, 1); end
                70: begin chk("r70_fd0", fd0, 1); chk("r70_busy0", busy0, 1); chk("r70_cnt0", cnt0, 1); end
                71: begin chk("r71_busy0", busy0, 1); chk("r71_sel0", sel0, 0); end
                default: ;
            endcase
        end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(45);

`ifdef SCAN_SKIP_EN
        // Sparse mask: channels 0, 2, 7 only; empty mask blocks start.
        rst  = 1'b1;
        mask = 8'b1000_0101;
        tick(1);
        rst   = 1'b0;
        start = 1'b1;
        for (int unsigned c = 1; c <= 16; c++) begin
            tick(1);
            if (c == 1) start = 1'b0;
            case (c)
                1:  begin chk("k1_sel0", sel0, 0); chk("k1_en0", en0, 1); end
                6:  chk("k6_sel0", sel0, 2);
                11: begin chk("k11_sel0", sel0, 7); chk("k11_en0", en0, 1); end
                15: begin chk("k15_fd0", fd0, 1); chk("k15_en0", en0, 0); chk("k15_cnt0", cnt0, 1); end
                16: begin chk("k16_sel0", sel0, 0); chk("k16_en0", en0, 1); end
                default: ;
            endcase
        end
        rst  = 1'b1;
        tick(1);
        rst   = 1'b0;
        mask  = 8'h00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("k_mask0_busy0", busy0, 0);
        chk("k_mask0_busy1", busy1, 0);
`endif

        // Randomised traffic; mask only changes while both instances idle.
        for (int unsigned c = 0; c < 3000; c++) begin
            tick(1);
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if (!m_run[0] && !m_run[1] && $urandom_range(0, 3) == 0) begin
                mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
